// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES types, constants and GF(2^8) / state-transform
//                helpers for the iterative AES-128 inverse cipher.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } state_e;

    // Multiply by x in GF(2^8) modulo 0x11b
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add
    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic byte_t gf_inv(input byte_t a);
        byte_t a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a6   = gmul(a3, a3);
        a12  = gmul(a6, a6);
        a15  = gmul(a12, a3);
        a30  = gmul(a15, a15);
        a60  = gmul(a30, a30);
        a120 = gmul(a60, a60);
        a240 = gmul(a120, a120);
        a252 = gmul(a240, a12);
        return gmul(a252, a2);
    endfunction

    // State byte at (row, col); column-major, s00 in the top byte
    function automatic byte_t get_byte(input state_t s, input int row, input int col);
        return s[127 - 8*(4*col + row) -: 8];
    endfunction

    // Row r rotates right by r byte positions
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*((c + r) % 4) + r) -: 8] = get_byte(s, r, c);
            end
        end
        return o;
    endfunction

    // Each column multiplied by the {0e,0b,0d,09} circulant
    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        byte_t  a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, 0, c);
            a1 = get_byte(s, 1, c);
            a2 = get_byte(s, 2, c);
            a3 = get_byte(s, 3, c);
            o[127 - 32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return o;
    endfunction

    // Round-key words arrive low-word-first: rk[31:0] is the key word for column 0
    function automatic state_t add_round_key(input state_t s, input state_t rk);
        return {s[127:96] ^ rk[31:0],
                s[95:64]  ^ rk[63:32],
                s[63:32]  ^ rk[95:64],
                s[31:0]   ^ rk[127:96]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_cipher_iter_if
//  Description : Command, round-key lookup and result bundle for the
//                iterative AES-128 inverse cipher.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_inv_cipher_iter_if;
    import aes_pkg::*;

    logic       start;
    state_t     ciphertext;
    logic [3:0] rk_addr;
    state_t     rk_data;
    logic       busy;
    logic       done;
    state_t     plaintextout;

    modport master (
        output start, ciphertext, rk_data,
        input  rk_addr, busy, done, plaintextout
    );

    modport slave (
        input  start, ciphertext, rk_data,
        output rk_addr, busy, done, plaintextout
    );

endinterface
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_sbox
//  Description : Combinational AES inverse S-box: inverse affine transform
//                followed by the GF(2^8) multiplicative inverse.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_sbox
    import aes_pkg::*;
(
    input  wire  [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_aff;

    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    assign w_aff = {i_byte[6:0], i_byte[7]}
                 ^ {i_byte[4:0], i_byte[7:5]}
                 ^ {i_byte[1:0], i_byte[7:2]}
                 ^ 8'h05;

    assign o_byte = gf_inv(w_aff);

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_cipher_iter
//  Description : Iterative AES-128 inverse cipher, one inverse round per
//                clock, round keys fetched from an external store.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input wire clk,
    input wire rst,
    aes_inv_cipher_iter_if.slave bus
);

    localparam logic [3:0] C_LAST_RK   = 4'(NR);
    localparam logic [3:0] C_FIRST_RND = 4'(NR - 1);

    generate
        if (NR != AES_NR) begin : g_nr_unsupported
            $error("aes_inv_cipher_iter: only NR = 10 (AES-128) is supported");
        end
    endgenerate

    state_e     r_fsm;
    logic [3:0] r_rnd;
    state_t     r_state;
    logic       r_busy;
    logic       r_done;
    state_t     r_pt;

    state_e     w_fsm_nxt;
    logic [3:0] w_rnd_nxt;
    state_t     w_state_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    state_t     w_pt_nxt;
    logic [3:0] w_rk_addr;

    state_t     w_isr;
    state_t     w_isb;
    state_t     w_ark;
    state_t     w_imc;

    // Shared round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
    assign w_isr = inv_shift_rows(r_state);

    generate
        for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
            aes_inv_sbox u_inv_sbox (
                .i_byte (w_isr[8*i +: 8]),
                .o_byte (w_isb[8*i +: 8])
            );
        end
    endgenerate

    assign w_ark = add_round_key(w_isb, bus.rk_data);
    assign w_imc = inv_mix_columns(w_ark);

    // Next-state, round counter, datapath and key-address selection
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_rnd_nxt   = r_rnd;
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pt_nxt    = r_pt;
        w_rk_addr   = C_LAST_RK;
        case (r_fsm)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = add_round_key(bus.ciphertext, bus.rk_data);
                    w_rnd_nxt   = C_FIRST_RND;
                    w_busy_nxt  = 1'b1;
                    w_fsm_nxt   = ROUND;
                end
            end
            ROUND: begin
                w_rk_addr = r_rnd;
                if (r_rnd != 4'd0) begin
                    w_state_nxt = w_imc;
                    w_rnd_nxt   = r_rnd - 4'd1;
                end else begin
                    // Final round skips InvMixColumns and lands in the output register
                    w_pt_nxt   = w_ark;
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                    w_fsm_nxt  = IDLE;
                end
            end
            default: begin
                w_fsm_nxt = IDLE;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_rnd   <= 4'd0;
            r_state <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pt    <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_rnd   <= w_rnd_nxt;
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pt    <= w_pt_nxt;
        end
    end

    assign bus.rk_addr      = w_rk_addr;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.plaintextout = r_pt;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_inv_cipher_iter
//  Description : Self-checking bench for aes_inv_cipher_iter: FIPS-197 known
//                answers, random vectors against a byte-array model, address
//                sequence, ignored start, mid-operation reset, back-to-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] C_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_ZK_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    logic rst;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sbox_t  [256];
    logic [7:0]   isbox_t [256];
    logic [31:0]  w       [44];
    logic [127:0] rk_table[16];
    logic [127:0] last_pt;

    always #5 clk = ~clk;

    aes_inv_cipher_iter_if bus ();

    // Round-key store: combinational lookup by the DUT's address
    assign bus.rk_data = rk_table[bus.rk_addr];

    aes_inv_cipher_iter #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box by brute-force inverse plus affine map, then invert the table
    task automatic build_tables();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[a]  = s;
            isbox_t[s] = 8'(a);
        end
    endtask

    // FIPS-197 key expansion; store keeps words in the low-word-first layout
    task automatic expand_key(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_table[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    // FIPS-197 InvCipher on a 4x4 byte matrix, using the expanded words in w[]
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ w[40 + c][31 - 8*r -: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][(c + r) % 4] = isbox_t[s[r][c]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = t[r][c] ^ w[4*rd + c][31 - 8*r -: 8];
            if (rd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    s[0][c] = mul(t[0][c], 8'h0e) ^ mul(t[1][c], 8'h0b) ^ mul(t[2][c], 8'h0d) ^ mul(t[3][c], 8'h09);
                    s[1][c] = mul(t[0][c], 8'h09) ^ mul(t[1][c], 8'h0e) ^ mul(t[2][c], 8'h0b) ^ mul(t[3][c], 8'h0d);
                    s[2][c] = mul(t[0][c], 8'h0d) ^ mul(t[1][c], 8'h09) ^ mul(t[2][c], 8'h0e) ^ mul(t[3][c], 8'h0b);
                    s[3][c] = mul(t[0][c], 8'h0b) ^ mul(t[1][c], 8'h0d) ^ mul(t[2][c], 8'h09) ^ mul(t[3][c], 8'h0e);
                end
            end else begin
                s = t;
            end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = s[r][c];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Cycle 0: present the command while the DUT sits in IDLE
    task automatic begin_op(input logic [127:0] key, input logic [127:0] ct);
        expand_key(key);
        bus.ciphertext = ct;
        bus.start      = 1'b1;
        chk("rk_addr c0", 128'(bus.rk_addr), 128'd10);
    endtask

    // Full operation; ign_cyc >= 1 pulses a stray start with junk data in that cycle
    task automatic run_op(input logic [127:0] key, input logic [127:0] ct,
                          input logic [127:0] exp, input int ign_cyc);
        begin_op(key, ct);
        for (int c = 1; c <= 11; c++) begin
            step();
            bus.start      = (c == ign_cyc);
            bus.ciphertext = rnd128();
            if (c <= 10) begin
                chk($sformatf("busy c%0d", c), 128'(bus.busy), 128'd1);
                chk($sformatf("done c%0d", c), 128'(bus.done), 128'd0);
                chk($sformatf("rk_addr c%0d", c), 128'(bus.rk_addr), 128'(10 - c));
                chk($sformatf("pt held c%0d", c), bus.plaintextout, last_pt);
            end else begin
                chk("done c11", 128'(bus.done), 128'd1);
                chk("busy c11", 128'(bus.busy), 128'd0);
                chk("rk_addr c11", 128'(bus.rk_addr), 128'd10);
                chk("plaintext c11", bus.plaintextout, exp);
            end
        end
        bus.start = 1'b0;
        last_pt   = exp;
    endtask

    task automatic idle_chk();
        step();
        chk("done single pulse", 128'(bus.done), 128'd0);
        chk("busy idle", 128'(bus.busy), 128'd0);
        chk("pt held idle", bus.plaintextout, last_pt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] key, ct, exp;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.ciphertext = '0;
        last_pt        = '0;
        for (int i = 0; i < 16; i++) rk_table[i] = '0;
        build_tables();

        // Reset state
        step();
        step();
        chk("reset busy", 128'(bus.busy), 128'd0);
        chk("reset done", 128'(bus.done), 128'd0);
        chk("reset pt", bus.plaintextout, 128'h0);
        chk("reset rk_addr", 128'(bus.rk_addr), 128'd10);
        rst = 1'b0;

        // FIPS-197 C.1 known answer, full address sequence
        run_op(C_C1_KEY, C_C1_CT, C_C1_PT, -1);
        idle_chk();

        // Zero key known answer
        run_op(128'h0, C_ZK_CT, 128'h0, -1);
        idle_chk();

        // Stray start in cycle 4 must be ignored
        run_op(C_C1_KEY, C_C1_CT, C_C1_PT, 4);
        idle_chk();

        // Reset in cycle 6 aborts with no done pulse
        begin_op(C_C1_KEY, C_C1_CT);
        for (int c = 1; c <= 6; c++) begin
            step();
            bus.start = 1'b0;
            chk($sformatf("busy pre-rst c%0d", c), 128'(bus.busy), 128'd1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst busy c7", 128'(bus.busy), 128'd0);
        chk("rst done c7", 128'(bus.done), 128'd0);
        chk("rst pt c7", bus.plaintextout, 128'h0);
        chk("rst rk_addr c7", 128'(bus.rk_addr), 128'd10);
        last_pt = '0;
        for (int c = 8; c <= 13; c++) begin
            step();
            chk($sformatf("no done after rst c%0d", c), 128'(bus.done), 128'd0);
        end
        run_op(C_C1_KEY, C_C1_CT, C_C1_PT, -1);

        // Back-to-back: zero-key start accepted in the done cycle
        run_op(128'h0, C_ZK_CT, 128'h0, -1);
        idle_chk();

        // Random vectors against the model, chained back-to-back
        for (int k = 0; k < 4; k++) begin
            key = rnd128();
            ct  = rnd128();
            expand_key(key);
            exp = model_decrypt(ct);
            run_op(key, ct, exp, (k == 2) ? 7 : -1);
        end
        idle_chk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
